// File: rtl/axi_pkg.sv
// Shared AXI constants and read/write FSM state types.
// Defining ROM_OUTREG_EN adds the R_FETCH2 read state for the extra pipeline stage.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif
`ifndef AXI_RESP_BITS
`define AXI_RESP_BITS 2
`endif

package axi_pkg;

    localparam int ID_W    = `AXI_ID_BITS;
    localparam int ADDR_W  = `AXI_ADDR_BITS;
    localparam int DATA_W  = `AXI_DATA_BITS;
    localparam int LEN_W   = `AXI_LEN_BITS;
    localparam int SIZE_W  = `AXI_SIZE_BITS;
    localparam int BURST_W = `AXI_BURST_BITS;
    localparam int RESP_W  = `AXI_RESP_BITS;
    localparam int STRB_W  = DATA_W / 8;

    localparam logic [RESP_W-1:0] RESP_OKAY   = RESP_W'(0);
    localparam logic [RESP_W-1:0] RESP_SLVERR = RESP_W'(2);
    localparam logic [RESP_W-1:0] RESP_DECERR = RESP_W'(3);

    localparam logic [BURST_W-1:0] BURST_FIXED = BURST_W'(0);
    localparam logic [BURST_W-1:0] BURST_INCR  = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_WRAP  = BURST_W'(2);

`ifdef ROM_OUTREG_EN
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_FETCH2, R_DATA} rd_state_t;
`else
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

endpackage

// File: rtl/axi_wr_err_resp.sv
// AXI write-channel error responder: accepts AW and all W beats, discards the data
// and answers every burst with SLVERR. Intended for read-only slaves.
module axi_wr_err_resp
    import axi_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ID_W-1:0]   i_awid,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic              i_wlast,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [ID_W-1:0]   o_bid,
    output logic [RESP_W-1:0] o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready
);

    wr_state_t       r_wr_state;
    wr_state_t       w_wr_state_next;
    logic            r_rst_done;
    logic [ID_W-1:0] r_bid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    // AWREADY stays low until the first edge after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_done <= 1'b0;
            r_bid      <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (i_awvalid && o_awready) begin
                r_bid <= i_awid;
            end
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        o_awready       = 1'b0;
        o_wready        = 1'b0;
        o_bvalid        = 1'b0;
        o_bresp         = RESP_OKAY;
        case (r_wr_state)
            W_IDLE: begin
                o_awready = r_rst_done;
                if (i_awvalid && r_rst_done) begin
                    w_wr_state_next = W_DATA;
                end
            end
            W_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid && i_wlast) begin
                    w_wr_state_next = W_RESP;
                end
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                o_bresp  = RESP_SLVERR;
                if (i_bready) begin
                    w_wr_state_next = W_IDLE;
                end
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

    assign o_bid = r_bid;

endmodule

// File: rtl/rom_wrapper.sv
// AXI read-only slave in front of a synchronous ROM macro; writes get SLVERR.
// Defining ROM_OUTREG_EN inserts an extra read-data register stage (R_FETCH2).
module rom_wrapper
    import axi_pkg::*;
#(
    parameter int ROM_ADDR_BITS = 12
)
(
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ID_W-1:0]          ARID_S,
    input  logic [ADDR_W-1:0]        ARADDR_S,
    input  logic [LEN_W-1:0]         ARLEN_S,
    input  logic [SIZE_W-1:0]        ARSIZE_S,
    input  logic [BURST_W-1:0]       ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,
    output logic [ID_W-1:0]          RID_S,
    output logic [DATA_W-1:0]        RDATA_S,
    output logic [RESP_W-1:0]        RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,
    input  logic [ID_W-1:0]          AWID_S,
    input  logic [ADDR_W-1:0]        AWADDR_S,
    input  logic [LEN_W-1:0]         AWLEN_S,
    input  logic [SIZE_W-1:0]        AWSIZE_S,
    input  logic [BURST_W-1:0]       AWBURST_S,
    input  logic                     AWVALID_S,
    output logic                     AWREADY_S,
    input  logic [DATA_W-1:0]        WDATA_S,
    input  logic [STRB_W-1:0]        WSTRB_S,
    input  logic                     WLAST_S,
    input  logic                     WVALID_S,
    output logic                     WREADY_S,
    output logic [ID_W-1:0]          BID_S,
    output logic [RESP_W-1:0]        BRESP_S,
    output logic                     BVALID_S,
    input  logic                     BREADY_S,
    output logic                     ROM_CS,
    output logic                     ROM_OE,
    output logic [ROM_ADDR_BITS-1:0] ROM_A,
    input  logic [DATA_W-1:0]        ROM_DO
);

    rd_state_t                r_rd_state;
    rd_state_t                w_rd_state_next;
    logic                     r_rst_done;
    logic [ID_W-1:0]          r_rid;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_cnt;
    logic [BURST_W-1:0]       r_burst;
    logic [ROM_ADDR_BITS-1:0] r_addr;
    logic [DATA_W-1:0]        r_rdata;
`ifdef ROM_OUTREG_EN
    logic [DATA_W-1:0]        r_rdata_pipe;
`endif

    logic                     w_ar_hs;
    logic                     w_r_hs;
    logic                     w_more;
    logic                     w_fetch;
    logic [ROM_ADDR_BITS-1:0] w_ar_addr;
    logic [ROM_ADDR_BITS-1:0] w_addr_step;
    logic                     w_unused;

    assign w_ar_hs     = ARVALID_S & ARREADY_S;
    assign w_r_hs      = RVALID_S & RREADY_S;
    assign w_more      = (r_cnt != r_len);
    assign w_ar_addr   = ARADDR_S[ROM_ADDR_BITS+1:2];
    assign w_addr_step = (r_burst == BURST_FIXED) ? r_addr : r_addr + ROM_ADDR_BITS'(1);

    // The ROM samples its address on the handshake edge, so the request is combinational.
    assign w_fetch = w_ar_hs | (w_r_hs & w_more);
    assign ROM_CS  = w_fetch;
    assign ROM_OE  = w_fetch;
    assign ROM_A   = w_ar_hs ? w_ar_addr : (w_fetch ? w_addr_step : r_addr);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        ARREADY_S       = 1'b0;
        RVALID_S        = 1'b0;
        RLAST_S         = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                ARREADY_S = r_rst_done;
                if (ARVALID_S && r_rst_done) begin
                    w_rd_state_next = R_FETCH;
                end
            end
`ifdef ROM_OUTREG_EN
            R_FETCH:  w_rd_state_next = R_FETCH2;
            R_FETCH2: w_rd_state_next = R_DATA;
`else
            R_FETCH:  w_rd_state_next = R_DATA;
`endif
            R_DATA: begin
                RVALID_S = 1'b1;
                RLAST_S  = (r_cnt == r_len);
                if (RREADY_S) begin
                    w_rd_state_next = w_more ? R_FETCH : R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    // r_addr always tracks the word currently being fetched or presented.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rst_done   <= 1'b0;
            r_rid        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_burst      <= '0;
            r_addr       <= '0;
            r_rdata      <= '0;
`ifdef ROM_OUTREG_EN
            r_rdata_pipe <= '0;
`endif
        end else begin
            r_rst_done <= 1'b1;
            if (w_ar_hs) begin
                r_rid   <= ARID_S;
                r_len   <= ARLEN_S;
                r_burst <= ARBURST_S;
                r_addr  <= w_ar_addr;
                r_cnt   <= '0;
            end else if (w_r_hs && w_more) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_addr <= w_addr_step;
            end
`ifdef ROM_OUTREG_EN
            if (r_rd_state == R_FETCH) begin
                r_rdata_pipe <= ROM_DO;
            end
            if (r_rd_state == R_FETCH2) begin
                r_rdata <= r_rdata_pipe;
            end
`else
            if (r_rd_state == R_FETCH) begin
                r_rdata <= ROM_DO;
            end
`endif
        end
    end

    assign RID_S   = r_rid;
    assign RDATA_S = r_rdata;
    assign RRESP_S = RESP_OKAY;

    axi_wr_err_resp u_wr_err (
        .i_clk     (ACLK),
        .i_rst_n   (ARESETn),
        .i_awid    (AWID_S),
        .i_awvalid (AWVALID_S),
        .o_awready (AWREADY_S),
        .i_wlast   (WLAST_S),
        .i_wvalid  (WVALID_S),
        .o_wready  (WREADY_S),
        .o_bid     (BID_S),
        .o_bresp   (BRESP_S),
        .o_bvalid  (BVALID_S),
        .i_bready  (BREADY_S)
    );

    // Size, high/low address bits and all write payload are intentionally ignored.
    assign w_unused = &{1'b0, ARSIZE_S, ARADDR_S[ADDR_W-1:ROM_ADDR_BITS+2], ARADDR_S[1:0],
                        AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, WDATA_S, WSTRB_S};

endmodule
